// File: rtl/magnet_driver_if.sv
// Command and status bundle between the board command decoder and the magnet driver.
// Master issues per-channel on/off/clear pulses; slave returns coil drive and status.
interface magnet_driver_if #(
  parameter int unsigned CH = 2
);
  logic [CH-1:0] on;
  logic [CH-1:0] off;
  logic [CH-1:0] clr_fault;
  logic [CH-1:0] magnet_n;
  logic [CH-1:0] active;
  logic [CH-1:0] fault;

  modport master (
    output on, off, clr_fault,
    input  magnet_n, active, fault
  );

  modport slave (
    input  on, off, clr_fault,
    output magnet_n, active, fault
  );
endinterface

// File: rtl/magnet_driver.sv
// Multi-channel electromagnet driver: pulse commands become held active-low coil drives
// with a full-power kick, PWM hold, max-on timeout with forced cooldown and sticky fault.
module magnet_driver #(
  parameter int unsigned CH            = 2,
  parameter int unsigned PWM_W         = 8,
  parameter int unsigned HOLD_DUTY     = 128,
  parameter int unsigned KICK_CYCLES   = 50_000,
  parameter int unsigned MAX_ON_CYCLES = 50_000_000,
  parameter int unsigned COOL_CYCLES   = 10_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  magnet_driver_if.slave  bus
);

  localparam int unsigned TW_MAX  = $clog2(MAX_ON_CYCLES + 1);
  localparam int unsigned TW_KICK = $clog2(KICK_CYCLES + 1);
  localparam int unsigned TW_COOL = $clog2(COOL_CYCLES + 1);
  localparam int unsigned TW_A    = (TW_MAX > TW_KICK) ? TW_MAX : TW_KICK;
  localparam int unsigned TW_B    = (TW_A > TW_COOL) ? TW_A : TW_COOL;
  // Timer is shared with the cooldown count, so it must also hold COOL_CYCLES.
  localparam int unsigned TW      = (TW_B < 1) ? 1 : TW_B;

  localparam logic [TW-1:0]  KICK_LAST = TW'(KICK_CYCLES - 1);
  localparam logic [TW-1:0]  MAX_LAST  = TW'(MAX_ON_CYCLES - 1);
  localparam logic [TW-1:0]  COOL_LAST = TW'(COOL_CYCLES - 1);
  localparam logic [TW-1:0]  TIMER_SAT = '1;
  localparam logic [PWM_W:0] DUTY      = (PWM_W + 1)'(HOLD_DUTY);
  localparam logic           TIMEOUT_EN = (MAX_ON_CYCLES != 0);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    KICK = 2'd1,
    HOLD = 2'd2,
    COOL = 2'd3
  } state_t;

  logic [PWM_W-1:0] pwm_cnt;
  logic             duty_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign duty_on = ({1'b0, pwm_cnt} < DUTY);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t        state;
    logic [TW-1:0] timer;
    logic          mag_q;
    logic          act_q;
    logic          flt_q;
    logic          timeout;

    assign timeout = TIMEOUT_EN && (timer == MAX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= OFF;
        timer <= '0;
        mag_q <= 1'b1;
        act_q <= 1'b0;
        flt_q <= 1'b0;
      end else begin
        // A fault set later in this block overrides the clear.
        if (bus.clr_fault[g]) begin
          flt_q <= 1'b0;
        end
        unique case (state)
          OFF: begin
            if (bus.on[g] && !bus.off[g] && !flt_q) begin
              state <= KICK;
              timer <= '0;
              mag_q <= 1'b0;
              act_q <= 1'b1;
            end
          end
          KICK, HOLD: begin
            if (timeout) begin
              state <= COOL;
              timer <= '0;
              mag_q <= 1'b1;
              act_q <= 1'b0;
              flt_q <= 1'b1;
            end else if (bus.off[g]) begin
              state <= OFF;
              mag_q <= 1'b1;
              act_q <= 1'b0;
            end else begin
              if (timer != TIMER_SAT) begin
                timer <= timer + 1'b1;
              end
              if (state == KICK && timer != KICK_LAST) begin
                mag_q <= 1'b0;
              end else begin
                state <= HOLD;
                mag_q <= !duty_on;
              end
            end
          end
          COOL: begin
            if (timer == COOL_LAST) begin
              state <= OFF;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: begin
            state <= OFF;
            mag_q <= 1'b1;
            act_q <= 1'b0;
          end
        endcase
      end
    end

    assign bus.magnet_n[g] = mag_q;
    assign bus.active[g]   = act_q;
    assign bus.fault[g]    = flt_q;
  end

endmodule

// File: tb/tb_magnet_driver.sv
// Self-checking bench for magnet_driver: directed scenarios plus random commands,
// compared against a cycle-age reference model of each channel.
module tb_magnet_driver;

  localparam int CH    = 2;
  localparam int PWM_W = 3;
  localparam int DUTY  = 2;
  localparam int KICK  = 4;
  localparam int MAXON = 20;
  localparam int COOL  = 6;
  localparam int PER   = 1 << PWM_W;

  logic clk;
  logic rst_n;

  magnet_driver_if #(.CH(CH)) bus ();

  magnet_driver #(
    .CH(CH),
    .PWM_W(PWM_W),
    .HOLD_DUTY(DUTY),
    .KICK_CYCLES(KICK),
    .MAX_ON_CYCLES(MAXON),
    .COOL_CYCLES(COOL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Model: age = cycles since turn-on (-1 when not energised), cool_left = remaining cooldown.
  int   age       [CH];
  int   cool_left [CH];
  bit   mfault    [CH];
  int   edge_cnt;
  logic [CH-1:0] exp_mag;
  logic [CH-1:0] exp_act;
  logic [CH-1:0] exp_flt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      age[i]       = -1;
      cool_left[i] = 0;
      mfault[i]    = 1'b0;
    end
    edge_cnt = 0;
    exp_mag  = '1;
    exp_act  = '0;
    exp_flt  = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] o, input logic [CH-1:0] f, input logic [CH-1:0] c);
    int pwm;
    bit set_f;
    pwm = edge_cnt % PER;
    edge_cnt++;
    for (int i = 0; i < CH; i++) begin
      set_f = 1'b0;
      if (cool_left[i] > 0) begin
        cool_left[i]--;
      end else if (age[i] >= 0) begin
        if (age[i] == MAXON - 1) begin
          age[i]       = -1;
          cool_left[i] = COOL;
          set_f        = 1'b1;
        end else if (f[i]) begin
          age[i] = -1;
        end else begin
          age[i]++;
        end
      end else if (o[i] && !f[i] && !mfault[i]) begin
        age[i] = 0;
      end
      if (set_f) mfault[i] = 1'b1;
      else if (c[i]) mfault[i] = 1'b0;
      exp_mag[i] = (age[i] >= 0 && (age[i] < KICK || pwm < DUTY)) ? 1'b0 : 1'b1;
      exp_act[i] = (age[i] >= 0);
      exp_flt[i] = mfault[i];
    end
  endtask

  task automatic cycle(input logic [CH-1:0] o, input logic [CH-1:0] f, input logic [CH-1:0] c);
    bus.on        = o;
    bus.off       = f;
    bus.clr_fault = c;
    @(posedge clk);
    model_step(o, f, c);
    @(negedge clk);
    check("magnet_n", 32'(bus.magnet_n), 32'(exp_mag));
    check("active",   32'(bus.active),   32'(exp_act));
    check("fault",    32'(bus.fault),    32'(exp_flt));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, '0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.on        = '0;
    bus.off       = '0;
    bus.clr_fault = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_magnet_n", 32'(bus.magnet_n), 32'h3);
    check("rst_active",   32'(bus.active),   32'h0);
    check("rst_fault",    32'(bus.fault),    32'h0);

    // Turn-on pulse on ch0: kick then PWM hold; ch1 untouched.
    cycle(2'b01, 2'b00, 2'b00);
    check("t2_kick_low", 32'(bus.magnet_n[0]), 32'h0);
    idle(15);
    check("t2_ch1_idle", 32'(bus.active[1]), 32'h0);

    // Turn-off before timeout: no fault.
    cycle(2'b00, 2'b01, 2'b00);
    check("t3_off_mag", 32'(bus.magnet_n[0]), 32'h1);
    check("t3_off_act", 32'(bus.active[0]),   32'h0);
    check("t3_no_fault", 32'(bus.fault[0]),   32'h0);

    // on[1] held: timeout, cooldown ignores on, fault blocks, clear then restart.
    for (int k = 0; k < 32; k++) cycle(2'b10, 2'b00, 2'b00);
    check("t4_fault_held", 32'(bus.fault[1]),  32'h1);
    check("t4_blocked",    32'(bus.active[1]), 32'h0);
    cycle(2'b00, 2'b00, 2'b10);
    cycle(2'b10, 2'b00, 2'b00);
    check("t4_restart", 32'(bus.active[1]), 32'h1);
    cycle(2'b00, 2'b10, 2'b00);

    // on&off together: no turn-on; retrigger during kick ignored.
    cycle(2'b01, 2'b01, 2'b00);
    check("t5_onoff", 32'(bus.active[0]), 32'h0);
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b01, 2'b00, 2'b00);
    cycle(2'b01, 2'b00, 2'b00);
    idle(MAXON + COOL);
    cycle(2'b00, 2'b00, 2'b01);

    // clr_fault on the timeout edge: set wins.
    cycle(2'b10, 2'b00, 2'b00);
    idle(MAXON - 1);
    cycle(2'b00, 2'b00, 2'b10);
    check("t6_set_wins", 32'(bus.fault[1]), 32'h1);
    idle(COOL);

    // Asynchronous reset in the middle of hold, ch1 still faulted.
    cycle(2'b01, 2'b00, 2'b00);
    idle(8);
    @(posedge clk);
    model_step('0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_async_mag", 32'(bus.magnet_n), 32'h3);
    check("t1_async_act", 32'(bus.active),   32'h0);
    check("t1_async_flt", 32'(bus.fault),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random command traffic.
    for (int k = 0; k < 600; k++) begin
      logic [CH-1:0] o, f, c;
      for (int i = 0; i < CH; i++) begin
        o[i] = ($urandom_range(0, 5) == 0);
        f[i] = ($urandom_range(0, 23) == 0);
        c[i] = ($urandom_range(0, 15) == 0);
      end
      cycle(o, f, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
